// File: rtl/register_file_bist_if.sv
// Register file write/read bus between the BIST initiator and the RF.
// The initiator drives addresses and write data; the RF returns read data.
interface register_file_bist_if;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdat1;
  logic [31:0] rdat2;

  modport master (
    output WEN, wsel, wdat, rsel1, rsel2,
    input  rdat1, rdat2
  );

  modport slave (
    input  WEN, wsel, wdat, rsel1, rsel2,
    output rdat1, rdat2
  );
endinterface

// File: rtl/register_file_bist.sv
// Register file self-test: write/readback of a per-address pattern and its
// inverse on both read ports, with pass flag, first failing address and count.
module register_file_bist #(
  parameter logic [31:0] SEED = 32'hA5C3_0F96
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        start,
  register_file_bist_if.master        rf,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [4:0]                  fail_addr,
  output logic [5:0]                  err_count
);

  typedef enum logic [2:0] {
    IDLE, WR0, RD0, WR1, RD1, DONE
  } state_t;

  state_t     state, nxt_state;
  logic [4:0] idx, nxt_idx;
  logic       last;
  logic       accept;
  logic       is_rd;
  logic       m1, m2;
  logic [6:0] sum;
  logic [5:0] new_cnt;

  function automatic logic [31:0] pat(input logic [4:0] a);
    return SEED ^ {27'b0, a};
  endfunction

  // r0 is hardwired to zero in the register file
  function automatic logic [31:0] expv(input state_t s,
                                       input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return (s == RD1) ? ~pat(a) : pat(a);
  endfunction

  assign last   = (idx == 5'd31);
  assign accept = (state == IDLE || state == DONE) && start;
  assign is_rd  = (state == RD0 || state == RD1);

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state = WR0;
          nxt_idx   = 5'd0;
        end
      end
      WR0: begin
        nxt_idx = idx + 5'd1;
        if (last) nxt_state = RD0;
      end
      RD0: begin
        nxt_idx = idx + 5'd1;
        if (last) nxt_state = WR1;
      end
      WR1: begin
        nxt_idx = idx + 5'd1;
        if (last) nxt_state = RD1;
      end
      RD1: begin
        nxt_idx = idx + 5'd1;
        if (last) nxt_state = DONE;
      end
      default: begin
        nxt_state = IDLE;
        nxt_idx   = 5'd0;
      end
    endcase
  end

  assign m1 = is_rd && (rf.rdat1 != expv(state, rf.rsel1));
  assign m2 = is_rd && (rf.rdat2 != expv(state, rf.rsel2));
  assign sum = {1'b0, err_count} + {6'b0, m1} + {6'b0, m2};
  assign new_cnt = (sum > 7'd63) ? 6'd63 : sum[5:0];

  // Bus outputs are registered from the next state/index so they line
  // up with the cycle the FSM is in.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      idx       <= 5'd0;
      rf.WEN    <= 1'b0;
      rf.wsel   <= 5'd0;
      rf.wdat   <= 32'd0;
      rf.rsel1  <= 5'd0;
      rf.rsel2  <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= 5'd0;
      err_count <= 6'd0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      rf.WEN   <= (nxt_state == WR0 || nxt_state == WR1);
      rf.wsel  <= (nxt_state == WR0 || nxt_state == WR1) ? nxt_idx : 5'd0;
      rf.wdat  <= (nxt_state == WR0) ? pat(nxt_idx) :
                  (nxt_state == WR1) ? ~pat(nxt_idx) : 32'd0;
      rf.rsel1 <= (nxt_state == RD0 || nxt_state == RD1) ? nxt_idx : 5'd0;
      rf.rsel2 <= (nxt_state == RD0 || nxt_state == RD1) ?
                  5'd31 - nxt_idx : 5'd0;
      busy     <= (nxt_state == WR0 || nxt_state == RD0 ||
                   nxt_state == WR1 || nxt_state == RD1);
      done     <= (nxt_state == DONE);
      if (accept) begin
        err_count <= 6'd0;
        fail_addr <= 5'd0;
        pass      <= 1'b0;
      end else if (is_rd) begin
        err_count <= new_cnt;
        // count never returns to zero within a run, so zero marks "first"
        if ((m1 || m2) && err_count == 6'd0)
          fail_addr <= m1 ? rf.rsel1 : rf.rsel2;
        if (state == RD1 && last)
          pass <= (new_cnt == 6'd0);
      end
    end
  end

endmodule

// File: tb/tb_register_file_bist.sv
// Directed bench for register_file_bist with a behavioural register file
// that can inject stuck bits, a writable r0 or an all-zero read path.
module tb_register_file_bist;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_addr;
  logic [5:0]  err_count;

  int n_cmp;
  int n_bad;
  int mode;

  logic [31:0] regs [32];

  register_file_bist_if rf ();

  register_file_bist dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .rf        (rf.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_count (err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_ff @(posedge CLK)
    if (rf.WEN) regs[rf.wsel] <= rf.wdat;

  // mode 0 ideal, 1 reg5 bit3 stuck-at-0, 2 r0 stores writes, 3 reads zero
  function automatic logic [31:0] rd(input logic [4:0] a, input int m);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : regs[a];
    if (m == 1 && a == 5'd5) v = v & ~32'h8;
    if (m == 2) v = regs[a];
    if (m == 3) v = 32'd0;
    return v;
  endfunction

  always_comb begin
    rf.rdat1 = rd(rf.rsel1, mode);
    rf.rdat2 = rd(rf.rsel2, mode);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rst_at > 0 pulses nRST once that many cycles after start
  task automatic run(input bit hold, input int rst_at);
    int cnt;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("wr0_wen", {31'b0, rf.WEN}, 32'd1);
    check("wr0_idx0", rf.wdat, 32'hA5C3_0F96);
    check("busy_up", {31'b0, busy}, 32'd1);
    cnt = 0;
    while (busy && cnt < 300) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (cnt == 3) begin
        check("wr0_wsel3", {27'b0, rf.wsel}, 32'd3);
        check("wr0_wdat3", rf.wdat, 32'hA5C3_0F95);
      end
      if (hold && cnt == 40) start = 1'b1;
      if (hold && cnt == 50) start = 1'b0;
      if (cnt == rst_at) begin
        check("wr1_wsel7", {27'b0, rf.wsel}, 32'd7);
        check("wr1_wdat7", rf.wdat, 32'h5A3C_F06E);
        nRST = 1'b0;
        #1;
        check("rst_wen", {31'b0, rf.WEN}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wdat", rf.wdat, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
      end
    end
    if (rst_at == 0) begin
      check("busy_cycles", cnt, 32'd128);
      check("done", {31'b0, done}, 32'd1);
      check("done_wen", {31'b0, rf.WEN}, 32'd0);
    end
  endtask

  task automatic result(input string tag, input logic p,
                        input logic [5:0] e, input logic [4:0] f);
    check({tag, "_pass"}, {31'b0, pass}, {31'b0, p});
    check({tag, "_err"}, {26'b0, err_count}, {26'b0, e});
    check({tag, "_faddr"}, {27'b0, fail_addr}, {27'b0, f});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mode  = 0;
    start = 1'b0;
    nRST  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wen0", {31'b0, rf.WEN}, 32'd0);
    check("rst_busy0", {31'b0, busy}, 32'd0);
    check("rst_done0", {31'b0, done}, 32'd0);
    check("rst_pass0", {31'b0, pass}, 32'd0);
    check("rst_err0", {26'b0, err_count}, 32'd0);
    check("rst_rsel2", {27'b0, rf.rsel2}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_busy", {31'b0, busy}, 32'd0);

    mode = 0;
    run(1'b0, 0);
    result("ideal", 1'b1, 6'd0, 5'd0);

    // ~P(5) has bit3 set, read on port 1 at idx 5 and port 2 at idx 26
    mode = 1;
    run(1'b0, 0);
    result("stuck", 1'b0, 6'd2, 5'd5);

    mode = 2;
    run(1'b0, 0);
    result("r0wr", 1'b0, 6'd4, 5'd0);

    mode = 0;
    run(1'b1, 0);
    result("hold", 1'b1, 6'd0, 5'd0);

    // WR1 idx 7 is 71 cycles after the start edge
    run(1'b0, 71);
    check("after_rst_done", {31'b0, done}, 32'd0);
    run(1'b0, 0);
    result("rerun", 1'b1, 6'd0, 5'd0);

    // idx 0: port 1 reads r0 (matches), port 2 reads r31 (mismatch)
    mode = 3;
    run(1'b0, 0);
    result("zero", 1'b0, 6'd63, 5'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
